// File: rtl/xor_serial_sequencer_if.sv
// ---------------------------------------------------------------------------
// xor_serial_sequencer_if
//
// Purpose:
//   Bundles the requester-side signals of the serial XOR sequencer so the
//   requester and the sequencer can be connected through one port.
//
// Signals:
//   start    requester -> sequencer   request pulse
//   a, b     requester -> sequencer   WIDTH-bit operands
//   busy     sequencer -> requester   high while bits are being processed
//   done     sequencer -> requester   one-cycle completion pulse
//   result   sequencer -> requester   a XOR b, filled LSB first
//   parity   sequencer -> requester   XOR-reduction of result bits so far
//   bit_idx  sequencer -> requester   bit pair currently in the XOR cell
//
// Modports:
//   master   requester view
//   slave    sequencer view
// ---------------------------------------------------------------------------
interface xor_serial_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             parity;
    logic [IDXW-1:0]  bit_idx;

    modport master (
        output start, a, b,
        input  busy, done, result, parity, bit_idx
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, parity, bit_idx
    );
endinterface

// File: rtl/xor_serial_sequencer.sv
// ---------------------------------------------------------------------------
// xor_serial_sequencer
//
// Purpose:
//   Computes result = a XOR b one bit pair per clock, LSB first, through a
//   single shared NOR-only XOR cell, and accumulates the parity of the
//   result bits as they are produced.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    xor_serial_sequencer_if.slave (start, a, b in;
//          busy, done, result, parity, bit_idx out)
//
// Operation:
//   IDLE/DONE accept start (operands latched), RUN walks bit_idx 0..WIDTH-1,
//   DONE lasts one cycle. A start seen in DONE launches the next operation
//   without an idle bubble. All outputs come straight from flops.
// ---------------------------------------------------------------------------

// Two-input XOR built only from two-input NOR gates.
//   n1 = ~(x | y)
//   n2 = ~(x | n1) = ~x & y
//   n3 = ~(y | n1) =  x & ~y
//   n4 = ~(n2 | n3) = XNOR
//   z  = ~(n4 | n4) = XOR
module xor_nor_cell (
    input  logic x_i,
    input  logic y_i,
    output logic z_o
);
    logic n1;
    logic n2;
    logic n3;
    logic n4;

    assign n1  = ~(x_i | y_i);
    assign n2  = ~(x_i | n1);
    assign n3  = ~(y_i | n1);
    assign n4  = ~(n2 | n3);
    assign z_o = ~(n4 | n4);
endmodule

module xor_serial_sequencer #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    xor_serial_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] op_a_q,   op_a_d;
    logic [WIDTH-1:0] op_b_q,   op_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             parity_q, parity_d;
    logic [IDXW-1:0]  bit_idx_q, bit_idx_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             cell_x;
    logic             cell_y;
    logic             cell_z;

    // The one and only XOR cell, fed by a mux over the latched operands.
    assign cell_x = op_a_q[bit_idx_q];
    assign cell_y = op_b_q[bit_idx_q];

    xor_nor_cell u_cell (
        .x_i (cell_x),
        .y_i (cell_y),
        .z_o (cell_z)
    );

    // Next-state and next-output logic. busy/done are computed for the
    // state being entered so they can be registered alongside it.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        result_d  = result_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    op_a_d    = bus.a;
                    op_b_d    = bus.b;
                    result_d  = '0;
                    parity_d  = 1'b0;
                    bit_idx_d = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                result_d[bit_idx_q] = cell_z;
                // Parity toggles on every 1 produced by the cell, which keeps
                // the cell as the only XOR function in the block.
                parity_d = cell_z ? ~parity_q : parity_q;
                if (bit_idx_q == LAST_IDX) begin
                    bit_idx_d = '0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    busy_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any pending request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            result_q  <= result_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.parity  = parity_q;
    assign bus.bit_idx = bit_idx_q;

endmodule

// File: tb/tb_xor_serial_sequencer.sv
// ---------------------------------------------------------------------------
// tb_xor_serial_sequencer
//
// Directed bench for xor_serial_sequencer (WIDTH=8). Stimulus pushes the
// expected {result, parity} of every launched operation into a queue; a
// monitor pops and compares on each done pulse. Cycle-level behaviour
// (busy window, bit_idx stepping, progressive fill, reset) is checked
// directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_xor_serial_sequencer;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    logic clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             parity;
    } exp_t;

    exp_t expq[$];

    xor_serial_sequencer_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

    xor_serial_sequencer #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            checkOutput("busy_with_done", {31'd0, bus.busy}, 32'd0);
            if (expq.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                checkOutput("done_result", {24'd0, bus.result}, {24'd0, e.result});
                checkOutput("done_parity", {31'd0, bus.parity}, {31'd0, e.parity});
            end
        end
    end

    // Follows one operation from cycle E+1 through the done cycle E+9.
    // injectAt >= 0 pulses start with new operands in that RUN cycle.
    task automatic trackOp(input logic [7:0] opa, input logic [7:0] opb,
                           input int injectAt);
        logic [7:0] res;
        logic [7:0] mask;
        logic [7:0] part;
        res = opa ^ opb;
        for (int k = 0; k < WIDTH; k++) begin
            mask = 8'((1 << k) - 1);
            part = res & mask;
            checkOutput($sformatf("run_busy_k%0d", k), {31'd0, bus.busy}, 32'd1);
            checkOutput($sformatf("run_done_k%0d", k), {31'd0, bus.done}, 32'd0);
            checkOutput($sformatf("run_idx_k%0d", k), {29'd0, bus.bit_idx}, k);
            checkOutput($sformatf("run_fill_k%0d", k), {24'd0, bus.result}, {24'd0, part});
            checkOutput($sformatf("run_par_k%0d", k), {31'd0, bus.parity}, {31'd0, ^part});
            if (k == injectAt) begin
                bus.start = 1'b1;
                bus.a     = 8'h0F;
                bus.b     = 8'hF0;
                tick();
                bus.start = 1'b0;
            end else begin
                tick();
            end
        end
        checkOutput("done_pulse", {31'd0, bus.done}, 32'd1);
        checkOutput("done_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("done_idx", {29'd0, bus.bit_idx}, 32'd0);
    endtask

    // Launch one operation; hold keeps start asserted after acceptance.
    task automatic applyStimulus(input logic [7:0] opa, input logic [7:0] opb,
                                 input bit hold, input int injectAt);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = opa;
        bus.b     = opb;
        tick();
        if (!hold) bus.start = 1'b0;
        e.result = opa ^ opb;
        e.parity = ^(opa ^ opb);
        expq.push_back(e);
        trackOp(opa, opb, injectAt);
    endtask

    // A couple of cycles after done: idle, outputs held.
    task automatic checkIdle(input logic [7:0] expRes, input logic expPar);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);
            checkOutput("idle_done", {31'd0, bus.done}, 32'd0);
            checkOutput("idle_result", {24'd0, bus.result}, {24'd0, expRes});
            checkOutput("idle_parity", {31'd0, bus.parity}, {31'd0, expPar});
        end
    endtask

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_result", {24'd0, bus.result}, 32'd0);
        checkOutput("rst_parity", {31'd0, bus.parity}, 32'd0);
        checkOutput("rst_idx", {29'd0, bus.bit_idx}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic A5^3C");
        applyStimulus(8'hA5, 8'h3C, 1'b0, -1);
        checkIdle(8'h99, 1'b0);

        $display("[TB] parity cases");
        applyStimulus(8'h01, 8'h00, 1'b0, -1);
        checkIdle(8'h01, 1'b1);
        applyStimulus(8'h5A, 8'h5A, 1'b0, -1);
        checkIdle(8'h00, 1'b0);

        $display("[TB] progressive fill FF^00");
        applyStimulus(8'hFF, 8'h00, 1'b0, -1);
        checkIdle(8'hFF, 1'b0);

        $display("[TB] start ignored while busy");
        applyStimulus(8'hA5, 8'h3C, 1'b0, 3);
        checkIdle(8'h99, 1'b0);

        $display("[TB] reset mid-run");
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("pre_rst_fill", {24'd0, bus.result}, 32'h07);
        rst_n = 1'b0;
        tick();
        // Request presented on the second reset edge must be swallowed.
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h00;
        tick();
        checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midrst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("midrst_result", {24'd0, bus.result}, 32'd0);
        checkOutput("midrst_parity", {31'd0, bus.parity}, 32'd0);
        checkOutput("midrst_idx", {29'd0, bus.bit_idx}, 32'd0);
        rst_n = 1'b1;
        // First edge with reset released accepts the held start.
        tick();
        bus.start = 1'b0;
        e.result = 8'h01;
        e.parity = 1'b1;
        expq.push_back(e);
        trackOp(8'h01, 8'h00, -1);
        checkIdle(8'h01, 1'b1);

        $display("[TB] back-to-back FF^0F");
        applyStimulus(8'hFF, 8'h0F, 1'b1, -1);
        e.result = 8'hF0;
        e.parity = 1'b0;
        expq.push_back(e);
        tick();
        bus.start = 1'b0;
        trackOp(8'hFF, 8'h0F, -1);
        checkIdle(8'hF0, 1'b0);

        tick();
        checkOutput("queue_empty", expq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
